// File: rtl/maindec_mc.sv
// Registered main decoder at the ID/EX boundary of the RV32 pipeline.
// Adds stall/flush handling, an illegal-opcode flag and a multicycle MUL/DIV hold of ID.
module maindec_mc #(
    parameter bit ENABLE_M   = 1'b1,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 16,
    parameter int CNT_W      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid_i,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    input  logic       ex_stall_i,
    input  logic       flush_i,
    output logic       id_stall_o,
    output logic       valid_o,
    output logic       RegWrite,
    output logic [2:0] ImmSrc,
    output logic       ALUSrc,
    output logic       MemWrite,
    output logic [2:0] ResultSrc,
    output logic [1:0] ALUOp,
    output logic       PCResultSrc,
    output logic       muldiv_o,
    output logic       illegal_o
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Control word layout: {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, ALUOp, PCResultSrc}
    function automatic logic [12:0] decode(input logic [6:0] op);
        logic [12:0] res;
        res = 13'b0;
        case (op)
            7'h03:   res = {12'b1_000_1_0_001_00_0, 1'b0};
            7'h23:   res = {12'b0_001_1_1_000_00_0, 1'b0};
            7'h33:   res = {12'b1_000_0_0_000_10_0, 1'b0};
            7'h63:   res = {12'b0_010_0_0_000_01_0, 1'b0};
            7'h13:   res = {12'b1_000_1_0_000_10_0, 1'b0};
            7'h6F:   res = {12'b1_011_0_0_010_00_0, 1'b0};
            7'h17:   res = {12'b1_100_0_0_100_00_0, 1'b0};
            7'h37:   res = {12'b1_100_0_0_011_00_0, 1'b0};
            7'h67:   res = {12'b1_000_1_0_010_10_1, 1'b0};
            default: res = {12'b0, 1'b1};
        endcase
        return res;
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       r_hold_op;
    logic [11:0]      r_ctrl;
    logic             r_valid;
    logic             r_muldiv;
    logic             r_illegal;

    logic [12:0] w_dec;
    logic [12:0] w_hold_dec;
    logic        w_m_start;

    assign w_dec      = decode(op_i);
    assign w_hold_dec = decode(r_hold_op);
    assign w_m_start  = ENABLE_M && id_valid_i && (op_i == 7'h33) && (funct7_i == 7'b0000001)
                        && !ex_stall_i && !flush_i;

    // ID is released only on the edge where the BUSY op completes
    assign id_stall_o = (r_state == S_BUSY) ? (ex_stall_i || (r_cnt != CNT_ONE))
                                            : (ex_stall_i || w_m_start);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_hold_op <= '0;
            r_ctrl    <= '0;
            r_valid   <= 1'b0;
            r_muldiv  <= 1'b0;
            r_illegal <= 1'b0;
        end else if (flush_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ctrl    <= '0;
            r_valid   <= 1'b0;
            r_muldiv  <= 1'b0;
            r_illegal <= 1'b0;
        end else if (!ex_stall_i) begin
            case (r_state)
                S_IDLE: begin
                    if (w_m_start) begin
                        r_hold_op <= op_i;
                        r_cnt     <= funct3_i[2] ? DIV_INIT : MUL_INIT;
                        r_state   <= S_BUSY;
                        r_ctrl    <= '0;
                        r_valid   <= 1'b0;
                        r_muldiv  <= 1'b0;
                        r_illegal <= 1'b0;
                    end else begin
                        r_ctrl    <= id_valid_i ? w_dec[12:1] : 12'b0;
                        r_valid   <= id_valid_i;
                        r_muldiv  <= 1'b0;
                        r_illegal <= id_valid_i && w_dec[0];
                    end
                end
                S_BUSY: begin
                    if (r_cnt == CNT_ONE) begin
                        r_ctrl    <= w_hold_dec[12:1];
                        r_valid   <= 1'b1;
                        r_muldiv  <= 1'b1;
                        r_illegal <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt     <= r_cnt - CNT_ONE;
                        r_ctrl    <= '0;
                        r_valid   <= 1'b0;
                        r_muldiv  <= 1'b0;
                        r_illegal <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign valid_o     = r_valid;
    assign RegWrite    = r_ctrl[11];
    assign ImmSrc      = r_ctrl[10:8];
    assign ALUSrc      = r_ctrl[7];
    assign MemWrite    = r_ctrl[6];
    assign ResultSrc   = r_ctrl[5:3];
    assign ALUOp       = r_ctrl[2:1];
    assign PCResultSrc = r_ctrl[0];
    assign muldiv_o    = r_muldiv;
    assign illegal_o   = r_illegal;

endmodule

// File: tb/tb_maindec_mc.sv
// Bench for maindec_mc: directed scenarios plus randomized traffic against a cycle model,
// with a second instance built without the M extension.
module tb_maindec_mc;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 16;

    // Decode table, control word = {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, ALUOp, PCResultSrc}
    localparam logic [6:0]  TBL_OP   [9] = '{7'h03, 7'h23, 7'h33, 7'h63, 7'h13, 7'h6F, 7'h17, 7'h37, 7'h67};
    localparam logic [11:0] TBL_CTRL [9] = '{12'b1_000_1_0_001_00_0, 12'b0_001_1_1_000_00_0,
                                             12'b1_000_0_0_000_10_0, 12'b0_010_0_0_000_01_0,
                                             12'b1_000_1_0_000_10_0, 12'b1_011_0_0_010_00_0,
                                             12'b1_100_0_0_100_00_0, 12'b1_100_0_0_011_00_0,
                                             12'b1_000_1_0_010_10_1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] f3 = '0;
    logic [6:0] f7 = '0;
    logic       ex_stall = 1'b0;
    logic       flush = 1'b0;

    logic       s1, v1, rw1, as1, mw1, pcr1, md1, il1;
    logic [2:0] imm1, res1;
    logic [1:0] alu1;
    logic       s0, v0, rw0, as0, mw0, pcr0, md0, il0;
    logic [2:0] imm0, res0;
    logic [1:0] alu0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    maindec_mc #(.ENABLE_M(1'b1), .MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .op_i(op), .funct3_i(f3), .funct7_i(f7),
        .ex_stall_i(ex_stall), .flush_i(flush), .id_stall_o(s1), .valid_o(v1), .RegWrite(rw1),
        .ImmSrc(imm1), .ALUSrc(as1), .MemWrite(mw1), .ResultSrc(res1), .ALUOp(alu1),
        .PCResultSrc(pcr1), .muldiv_o(md1), .illegal_o(il1));

    maindec_mc #(.ENABLE_M(1'b0), .MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT), .CNT_W(5)) dut_nom (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .op_i(op), .funct3_i(f3), .funct7_i(f7),
        .ex_stall_i(ex_stall), .flush_i(flush), .id_stall_o(s0), .valid_o(v0), .RegWrite(rw0),
        .ImmSrc(imm0), .ALUSrc(as0), .MemWrite(mw0), .ResultSrc(res0), .ALUOp(alu0),
        .PCResultSrc(pcr0), .muldiv_o(md0), .illegal_o(il0));

    // Bundle layout: {valid, ctrl[11:0], muldiv, illegal}
    logic [14:0] b1, b0;
    logic [11:0] c1;
    assign c1 = {rw1, imm1, as1, mw1, res1, alu1, pcr1};
    assign b1 = {v1, c1, md1, il1};
    assign b0 = {v0, rw0, imm0, as0, mw0, res0, alu0, pcr0, md0, il0};

    function automatic logic [14:0] ref_decode(input logic v, input logic [6:0] o, input logic md);
        logic [14:0] r;
        r = '0;
        if (v) begin
            r = {1'b1, 12'b0, 1'b0, 1'b1};
            for (int k = 0; k < 9; k++)
                if (TBL_OP[k] == o) r = {1'b1, TBL_CTRL[k], md, 1'b0};
        end
        return r;
    endfunction

    function automatic logic is_m(input logic v, input logic [6:0] o, input logic [6:0] fn7);
        return v && (o == 7'h33) && (fn7 == 7'b0000001);
    endfunction

    // Model: an accepted MUL/DIV retires after LAT-1 further unstalled cycles
    logic [14:0] m_exp, m0_exp;
    logic        m_busy;
    int          m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_exp <= '0; m0_exp <= '0; m_busy <= 1'b0; m_left <= 0;
        end else begin
            if (flush) m0_exp <= '0;
            else if (!ex_stall) m0_exp <= ref_decode(id_valid, op, 1'b0);
            if (flush) begin
                m_exp <= '0; m_busy <= 1'b0; m_left <= 0;
            end else if (!ex_stall) begin
                if (m_busy) begin
                    if (m_left == 1) begin
                        m_exp <= ref_decode(1'b1, 7'h33, 1'b1); m_busy <= 1'b0; m_left <= 0;
                    end else begin
                        m_exp <= '0; m_left <= m_left - 1;
                    end
                end else if (is_m(id_valid, op, f7)) begin
                    m_exp <= '0; m_busy <= 1'b1; m_left <= (f3[2] ? DIV_LAT : MUL_LAT) - 1;
                end else begin
                    m_exp <= ref_decode(id_valid, op, 1'b0);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic exp_stall;
        exp_stall = m_busy ? (ex_stall || (m_left != 1)) : (ex_stall || (is_m(id_valid, op, f7) && !flush));
        check("bundle", 32'(b1), 32'(m_exp));
        check("id_stall", 32'(s1), 32'(exp_stall));
        check("bundle_nom", 32'(b0), 32'(m0_exp));
        check("id_stall_nom", 32'(s0), 32'(ex_stall));
    end

    task automatic drive(input logic v, input logic [6:0] o, input logic [2:0] fn3,
                         input logic [6:0] fn7, input logic st, input logic fl);
        id_valid = v; op = o; f3 = fn3; f7 = fn7; ex_stall = st; flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        drive(1'b0, 7'h00, 3'b000, 7'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_bundle", 32'(b1), 32'h0);
        check("reset_stall", 32'(s1), 32'h0);
        rst_n = 1'b1;
        step();

        // Table sweep
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, TBL_OP[i], 3'b000, 7'h00, 1'b0, 1'b0);
            step();
            check("sweep_ctrl", 32'(c1), 32'(TBL_CTRL[i]));
            check("sweep_valid", 32'(v1), 32'h1);
            $display("sweep op=%02h ctrl=%03h valid=%0d", TBL_OP[i], c1, v1);
        end
        check("jalr_aluop", 32'(alu1), 32'h2);
        check("jalr_pcres", 32'(pcr1), 32'h1);
        drive(1'b1, 7'h03, 3'b010, 7'h00, 1'b0, 1'b0);
        step();
        check("load_ressrc", 32'(res1), 32'h1);
        check("load_alusrc", 32'(as1), 32'h1);

        // MUL timing
        drive(1'b1, 7'h33, 3'b000, 7'h01, 1'b0, 1'b0);
        #1 check("mul_stall_T", 32'(s1), 32'h1);
        step();
        check("mul_stall_T1", 32'(s1), 32'h1);
        check("mul_valid_T1", 32'(v1), 32'h0);
        step();
        check("mul_stall_T2", 32'(s1), 32'h0);
        check("mul_valid_T2", 32'(v1), 32'h0);
        step();
        check("mul_done", 32'({v1, md1, rw1}), 32'h7);
        $display("mul done valid=%0d muldiv=%0d", v1, md1);
        drive(1'b0, 7'h00, 3'b000, 7'h00, 1'b0, 1'b0);
        step();

        // DIV with a two-cycle EX stall mid-BUSY
        drive(1'b1, 7'h33, 3'b100, 7'h01, 1'b0, 1'b0);
        step();
        for (k = 2; k <= 40; k++) begin
            ex_stall = (k == 5 || k == 6);
            step();
            if (v1) break;
        end
        check("div_stall_latency", 32'(k), 32'd18);
        $display("div with stall completed after %0d edges", k);
        drive(1'b0, 7'h00, 3'b000, 7'h00, 1'b0, 1'b0);
        step();

        // Flush in the 5th BUSY cycle
        drive(1'b1, 7'h33, 3'b101, 7'h01, 1'b0, 1'b0);
        step();
        repeat (4) step();
        flush = 1'b1;
        step();
        check("flush_valid", 32'(v1), 32'h0);
        drive(1'b1, 7'h33, 3'b000, 7'h00, 1'b0, 1'b0);
        #1 check("flush_stall", 32'(s1), 32'h0);
        step();
        check("add_after_flush", 32'(b1), 32'({1'b1, 12'b1_000_0_0_000_10_0, 2'b00}));
        $display("flush then add: bundle=%04h", b1);

        // Illegal opcode
        drive(1'b1, 7'h7F, 3'b000, 7'h00, 1'b0, 1'b0);
        step();
        check("illegal_set", 32'({v1, c1, il1}), 32'({1'b1, 12'b0, 1'b1}));
        drive(1'b0, 7'h7F, 3'b000, 7'h00, 1'b0, 1'b0);
        step();
        check("illegal_novalid", 32'(il1), 32'h0);

        // Reset mid-DIV at counter 9
        drive(1'b1, 7'h33, 3'b100, 7'h01, 1'b0, 1'b0);
        step();
        repeat (6) step();
        rst_n = 1'b0;
        #1 check("rst_async_bundle", 32'(b1), 32'h0);
        id_valid = 1'b0;
        step();
        rst_n = 1'b1;
        #1 check("rst_release_stall", 32'(s1), 32'h0);
        step();
        $display("reset mid-busy done");

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int sel;
            sel = $urandom_range(0, 11);
            id_valid = ($urandom_range(0, 99) < 85);
            f3 = 3'($urandom);
            f7 = 7'h00;
            if (sel < 9) op = TBL_OP[sel];
            else if (sel == 10) op = 7'($urandom);
            else begin op = 7'h33; f7 = 7'h01; end
            if ($urandom_range(0, 9) == 0) f7 = 7'($urandom);
            ex_stall = ($urandom_range(0, 99) < 15);
            flush = ($urandom_range(0, 99) < 4);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
